// File: rtl/prefix_adder_pkg.sv
// Shared types and elaboration-time helpers for the pipelined Sklansky adder.
package prefix_adder_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Full prefix combine: hi spans the upper group, lo the group just below it.
  function automatic gp_t black_op(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  // Generate-only combine for positions whose group propagate is dead.
  function automatic gp_t grey_op(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = 1'b0;
    return r;
  endfunction

  // Number of registered prefix stages.
  function automatic int num_stages(input int width, input int lps);
    return (clog2(width) + lps - 1) / lps;
  endfunction

  // First Sklansky level handled by stage s (stages numbered from 1).
  function automatic int stage_first_level(input int s, input int lps);
    return (s - 1) * lps;
  endfunction

  // Levels handled by stage s; the last stage may be short.
  function automatic int stage_num_levels(input int s, input int width, input int lps);
    int rem;
    rem = clog2(width) - (s - 1) * lps;
    return (rem < lps) ? rem : lps;
  endfunction

endpackage

// File: rtl/prefix_stage.sv
// One pipeline slice: NUM_LEVELS Sklansky levels then an enabled register.
// The original propagate vector and carry-in ride along untouched.
module prefix_stage #(
  parameter int WIDTH       = 32,
  parameter int FIRST_LEVEL = 0,
  parameter int NUM_LEVELS  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] g_i,
  input  logic [WIDTH-1:0] p_i,
  input  logic [WIDTH-1:0] po_i,
  input  logic             c0_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] g_o,
  output logic [WIDTH-1:0] p_o,
  output logic [WIDTH-1:0] po_o,
  output logic             c0_o
);
  import prefix_adder_pkg::*;

  logic [WIDTH-1:0] g_nx, p_nx;

  // Prefix levels; the partner index never has bit k set, so in-place update is safe.
  always_comb begin : comb_levels
    gp_t lvl [WIDTH];
    g_nx = '0;
    p_nx = '0;
    for (int i = 0; i < WIDTH; i++) lvl[i] = {g_i[i], p_i[i]};
    for (int lv = 0; lv < NUM_LEVELS; lv++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (((i >> (FIRST_LEVEL + lv)) & 1) == 1)
          lvl[i] = black_op(lvl[i], lvl[((i >> (FIRST_LEVEL + lv)) << (FIRST_LEVEL + lv)) - 1]);
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      g_nx[i] = lvl[i].g;
      p_nx[i] = lvl[i].p;
    end
  end

  // Stage register: shifts on the global advance, bubbles included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_o <= 1'b0;
      g_o   <= '0;
      p_o   <= '0;
      po_o  <= '0;
      c0_o  <= 1'b0;
    end else if (en) begin
      vld_o <= vld_i;
      g_o   <= g_nx;
      p_o   <= p_nx;
      po_o  <= po_i;
      c0_o  <= c0_i;
    end
  end

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Sklansky adder/subtractor with valid/ready handshake.
// Stage 0 forms bitwise g/p, NPS prefix stages follow, sum is formed
// from the last stage register.
module prefix_adder_pipe #(
  parameter int WIDTH            = 32,
  parameter int LEVELS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);
  import prefix_adder_pkg::*;

  localparam int NPS = num_stages(WIDTH, LEVELS_PER_STAGE);

  logic             adv;
  logic             vld_pipe [NPS+1];
  logic [WIDTH-1:0] g_s  [NPS+1];
  logic [WIDTH-1:0] p_s  [NPS+1];
  logic [WIDTH-1:0] po_s [NPS+1];
  logic             c0_s [NPS+1];

  logic [WIDTH-1:0] b_eff, p_in, g_in;
  logic             c0_in;
  logic             vld0_q, c0_q;
  logic [WIDTH-1:0] g0_q, p0_q;

  // One enable for the whole pipe; never looks at in_valid.
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // Operand conditioning; carry-in folded into the bit-0 generate.
  always_comb begin
    b_eff = in_sub ? ~in_b : in_b;
    c0_in = in_sub | in_cin;
    p_in  = in_a ^ b_eff;
    g_in  = in_a & b_eff;
    g_in[0] = g_in[0] | (p_in[0] & c0_in);
  end

  // Stage 0 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld0_q <= 1'b0;
      g0_q   <= '0;
      p0_q   <= '0;
      c0_q   <= 1'b0;
    end else if (adv) begin
      vld0_q <= in_valid;
      g0_q   <= g_in;
      p0_q   <= p_in;
      c0_q   <= c0_in;
    end
  end

  assign vld_pipe[0] = vld0_q;
  assign g_s[0]      = g0_q;
  assign p_s[0]      = p0_q;
  assign po_s[0]     = p0_q;
  assign c0_s[0]     = c0_q;

  for (genvar s = 1; s <= NPS; s++) begin : g_stage
    prefix_stage #(
      .WIDTH      (WIDTH),
      .FIRST_LEVEL(stage_first_level(s, LEVELS_PER_STAGE)),
      .NUM_LEVELS (stage_num_levels(s, WIDTH, LEVELS_PER_STAGE))
    ) u_stage (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (adv),
      .vld_i(vld_pipe[s-1]),
      .g_i  (g_s[s-1]),
      .p_i  (p_s[s-1]),
      .po_i (po_s[s-1]),
      .c0_i (c0_s[s-1]),
      .vld_o(vld_pipe[s]),
      .g_o  (g_s[s]),
      .p_o  (p_s[s]),
      .po_o (po_s[s]),
      .c0_o (c0_s[s])
    );
  end

  // Group propagate of the final stage has no consumer.
  logic unused_p;
  assign unused_p = ^p_s[NPS];

  // Carry into bit i is the group generate of bits i-1..0.
  assign out_valid = vld_pipe[NPS];
  assign out_sum   = po_s[NPS] ^ {g_s[NPS][WIDTH-2:0], c0_s[NPS]};
  assign out_cout  = g_s[NPS][WIDTH-1];
  assign out_ovf   = g_s[NPS][WIDTH-2] ^ g_s[NPS][WIDTH-1];

endmodule
